// File: rtl/stream_pkg.sv
// Shared types and sizing helpers for the stream-operator slice datapath.
package stream_pkg;

    typedef enum logic {
        STREAM_RS = 1'b0,
        STREAM_LS = 1'b1
    } stream_dir_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_e;

    function automatic int nslice(input int dw, input int sw);
        return (dw + sw - 32'sd1) / sw;
    endfunction

endpackage

// File: rtl/stream_slice_serializer.sv
// Serializes a DATA_W word into SLICE_W beats in {>>} or {<<} streaming order.
// Valid bits of each beat are MSB-aligned; out_bits flags a short final beat.
module stream_slice_serializer
    import stream_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int SLICE_W = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DATA_W-1:0]            in_data,
    input  logic                         in_dir,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [SLICE_W-1:0]           out_data,
    output logic [$clog2(SLICE_W+1)-1:0] out_bits,
    output logic                         out_last
);

    localparam int NSLICE = nslice(DATA_W, SLICE_W);
    localparam int REM    = DATA_W % SLICE_W;
    localparam int CNT_W  = (NSLICE > 32'sd1) ? $clog2(NSLICE) : 32'sd1;
    localparam int BITS_W = $clog2(SLICE_W + 32'sd1);
    localparam int EXT_W  = NSLICE * SLICE_W;

    localparam logic [CNT_W-1:0]  LAST_IDX  = CNT_W'(NSLICE - 32'sd1);
    localparam logic [BITS_W-1:0] FULL_BITS = BITS_W'(SLICE_W);
    localparam logic [BITS_W-1:0] LAST_BITS = (REM != 32'sd0) ? BITS_W'(REM) : BITS_W'(SLICE_W);

    // The word sits in an EXT_W register padded to whole slices: right-stream
    // pads below the word and drains from the top, left-stream pads above and
    // drains from the bottom.
    function automatic logic [EXT_W-1:0] load_ext(input logic [DATA_W-1:0] word,
                                                  input stream_dir_e dir);
        logic [EXT_W-1:0] e;
        if (dir == STREAM_RS) begin
            e = EXT_W'(word) << (EXT_W - DATA_W);
        end else begin
            e = EXT_W'(word);
        end
        return e;
    endfunction

    function automatic logic [EXT_W-1:0] advance(input logic [EXT_W-1:0] ext,
                                                 input stream_dir_e dir);
        logic [EXT_W-1:0] e;
        if (dir == STREAM_RS) begin
            e = ext << SLICE_W;
        end else begin
            e = ext >> SLICE_W;
        end
        return e;
    endfunction

    function automatic logic [SLICE_W-1:0] beat_of(input logic [EXT_W-1:0] ext,
                                                   input stream_dir_e dir,
                                                   input logic last);
        logic [SLICE_W-1:0] b;
        if (dir == STREAM_RS) begin
            b = ext[EXT_W-1 -: SLICE_W];
        end else begin
            b = ext[SLICE_W-1:0];
            if (last && (REM != 32'sd0)) begin
                b = b << (SLICE_W - REM);
            end else begin
                b = b;
            end
        end
        return b;
    endfunction

    state_e              state_q, state_d;
    stream_dir_e         dir_q, dir_d;
    logic [CNT_W-1:0]    idx_q, idx_d;
    logic [EXT_W-1:0]    ext_q, ext_d;
    logic                out_valid_q, out_valid_d;
    logic [SLICE_W-1:0]  out_data_q, out_data_d;
    logic [BITS_W-1:0]   out_bits_q, out_bits_d;
    logic                out_last_q, out_last_d;
    logic                accept_s, in_ready_s, load_s, last_s;

    // Handshake decode, next-state and the registered beat presented next cycle.
    always_comb begin
        accept_s   = out_valid_q && out_ready;
        in_ready_s = (state_q == ST_IDLE) || (accept_s && out_last_q);
        load_s     = in_valid && in_ready_s;

        state_d = state_q;
        dir_d   = dir_q;
        idx_d   = idx_q;
        ext_d   = ext_q;

        if (load_s) begin
            state_d = ST_SEND;
            dir_d   = stream_dir_e'(in_dir);
            idx_d   = '0;
            ext_d   = load_ext(in_data, stream_dir_e'(in_dir));
        end else if (accept_s) begin
            if (out_last_q) begin
                state_d = ST_IDLE;
            end else begin
                idx_d = idx_q + CNT_W'(1'b1);
                ext_d = advance(ext_q, dir_q);
            end
        end else begin
            state_d = state_q;
        end

        last_s      = (idx_d == LAST_IDX);
        out_valid_d = (state_d == ST_SEND);
        if (out_valid_d) begin
            out_data_d = beat_of(ext_d, dir_d, last_s);
            out_bits_d = last_s ? LAST_BITS : FULL_BITS;
            out_last_d = last_s;
        end else begin
            out_data_d = '0;
            out_bits_d = '0;
            out_last_d = 1'b0;
        end
    end

    // State, shift register and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            dir_q       <= STREAM_RS;
            idx_q       <= '0;
            ext_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_bits_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            dir_q       <= dir_d;
            idx_q       <= idx_d;
            ext_q       <= ext_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_bits_q  <= out_bits_d;
            out_last_q  <= out_last_d;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_bits  = out_bits_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_stream_slice_serializer.sv
// Directed bench for stream_slice_serializer in three geometries: 32/8, 4/3 and 4/5.
module tb_stream_slice_serializer;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    // A: DATA_W=32, SLICE_W=8
    logic        a_in_valid, a_in_ready, a_in_dir, a_out_valid, a_out_ready, a_out_last;
    logic [31:0] a_in_data;
    logic [7:0]  a_out_data;
    logic [3:0]  a_out_bits;
    // B: DATA_W=4, SLICE_W=3
    logic        b_in_valid, b_in_ready, b_in_dir, b_out_valid, b_out_ready, b_out_last;
    logic [3:0]  b_in_data;
    logic [2:0]  b_out_data;
    logic [1:0]  b_out_bits;
    // C: DATA_W=4, SLICE_W=5
    logic        c_in_valid, c_in_ready, c_in_dir, c_out_valid, c_out_ready, c_out_last;
    logic [3:0]  c_in_data;
    logic [4:0]  c_out_data;
    logic [2:0]  c_out_bits;

    stream_slice_serializer #(.DATA_W(32), .SLICE_W(8)) u_a (
        .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_data(a_in_data), .in_dir(a_in_dir), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .out_data(a_out_data), .out_bits(a_out_bits),
        .out_last(a_out_last));

    stream_slice_serializer #(.DATA_W(4), .SLICE_W(3)) u_b (
        .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_data(b_in_data), .in_dir(b_in_dir), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .out_data(b_out_data), .out_bits(b_out_bits),
        .out_last(b_out_last));

    stream_slice_serializer #(.DATA_W(4), .SLICE_W(5)) u_c (
        .clk(clk), .rst_n(rst_n), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .in_data(c_in_data), .in_dir(c_in_dir), .out_valid(c_out_valid),
        .out_ready(c_out_ready), .out_data(c_out_data), .out_bits(c_out_bits),
        .out_last(c_out_last));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        a_in_valid = 1'b0; a_in_dir = 1'b0; a_in_data = 32'h0; a_out_ready = 1'b0;
        b_in_valid = 1'b0; b_in_dir = 1'b0; b_in_data = 4'h0;  b_out_ready = 1'b0;
        c_in_valid = 1'b0; c_in_dir = 1'b0; c_in_data = 4'h0;  c_out_ready = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({a_out_valid, a_out_last, a_in_ready} !== 3'b001) begin
            n_fail++; $display("FAIL reset_a_ctrl: got %b want 001", {a_out_valid, a_out_last, a_in_ready});
        end
        n_checks++;
        if ({a_out_data, a_out_bits} !== 12'h000) begin
            n_fail++; $display("FAIL reset_a_data: got %h want 000", {a_out_data, a_out_bits});
        end
        n_checks++;
        if ({b_out_valid, b_out_last, b_in_ready, b_out_data, b_out_bits} !== 8'b0010_0000) begin
            n_fail++; $display("FAIL reset_b: got %b want 00100000", {b_out_valid, b_out_last, b_in_ready, b_out_data, b_out_bits});
        end
        n_checks++;
        if ({c_out_valid, c_out_last, c_in_ready, c_out_data, c_out_bits} !== 11'b001_00000_000) begin
            n_fail++; $display("FAIL reset_c: got %b want 00100000000", {c_out_valid, c_out_last, c_in_ready, c_out_data, c_out_bits});
        end
        tick();
        rst_n = 1'b1;
    endtask

    // exp packs beat0 in the top byte down to beat3 in the bottom byte.
    task automatic test_word32(input logic dir, input logic [31:0] word, input logic [31:0] exp, input string name);
        logic [7:0] e;
        tick();
        a_in_valid = 1'b1; a_in_data = word; a_in_dir = dir; a_out_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({a_in_ready, a_out_valid} !== 2'b10) begin
            n_fail++; $display("FAIL %s_idle: ready/valid got %b want 10", name, {a_in_ready, a_out_valid});
        end
        tick();
        a_in_valid = 1'b0; a_in_data = 32'hDEADBEEF;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            e = exp[31-8*k -: 8];
            n_checks++;
            if ({a_out_valid, a_out_data, a_out_bits} !== {1'b1, e, 4'd8}) begin
                n_fail++; $display("FAIL %s_beat%0d: got v=%b d=%h b=%0d want v=1 d=%h b=8",
                                   name, k, a_out_valid, a_out_data, a_out_bits, e);
            end
            n_checks++;
            if ({a_out_last, a_in_ready} !== {k == 3, k == 3}) begin
                n_fail++; $display("FAIL %s_last%0d: last/ready got %b want %b", name, k,
                                   {a_out_last, a_in_ready}, {k == 3, k == 3});
            end
            tick();
        end
        @(negedge clk);
        n_checks++;
        if ({a_out_valid, a_in_ready} !== 2'b01) begin
            n_fail++; $display("FAIL %s_done: valid/ready got %b want 01", name, {a_out_valid, a_in_ready});
        end
    endtask

    task automatic test_partial(input logic dir, input logic [2:0] e0, input logic [2:0] e1,
                                input logic [3:0] exp_cat, input string name);
        logic [2:0] d0, d1;
        tick();
        b_in_valid = 1'b1; b_in_data = 4'b0001; b_in_dir = dir; b_out_ready = 1'b1;
        tick();
        b_in_valid = 1'b0; b_in_data = 4'b1111;
        @(negedge clk);
        d0 = b_out_data;
        n_checks++;
        if ({b_out_valid, b_out_data, b_out_bits, b_out_last} !== {1'b1, e0, 2'd3, 1'b0}) begin
            n_fail++; $display("FAIL %s_beat0: got v=%b d=%b b=%0d l=%b want v=1 d=%b b=3 l=0",
                               name, b_out_valid, b_out_data, b_out_bits, b_out_last, e0);
        end
        tick();
        @(negedge clk);
        d1 = b_out_data;
        n_checks++;
        if ({b_out_valid, b_out_data, b_out_bits, b_out_last} !== {1'b1, e1, 2'd1, 1'b1}) begin
            n_fail++; $display("FAIL %s_beat1: got v=%b d=%b b=%0d l=%b want v=1 d=%b b=1 l=1",
                               name, b_out_valid, b_out_data, b_out_bits, b_out_last, e1);
        end
        n_checks++;
        if ({d0, d1[2]} !== exp_cat) begin
            n_fail++; $display("FAIL %s_concat: got %b want %b", name, {d0, d1[2]}, exp_cat);
        end
        tick();
    endtask

    task automatic test_single();
        int fires = 0;
        int beats = 0;
        tick();
        c_in_valid = 1'b1; c_in_data = 4'b0001; c_in_dir = 1'b1; c_out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            if (c_in_valid && c_in_ready) fires++;
            if (c_out_valid && c_out_ready) beats++;
            if (i != 0) begin
                n_checks++;
                if ({c_out_valid, c_out_data, c_out_bits, c_out_last, c_in_ready} !== {1'b1, 5'b00010, 3'd4, 1'b1, 1'b1}) begin
                    n_fail++; $display("FAIL single_beat%0d: got v=%b d=%b b=%0d l=%b r=%b want v=1 d=00010 b=4 l=1 r=1",
                                       i, c_out_valid, c_out_data, c_out_bits, c_out_last, c_in_ready);
                end
            end
            tick();
        end
        c_in_valid = 1'b0;
        @(negedge clk);
        if (c_out_valid && c_out_ready) beats++;
        tick();
        @(negedge clk);
        n_checks++;
        if (c_out_valid !== 1'b0) begin
            n_fail++; $display("FAIL single_idle: out_valid got %b want 0", c_out_valid);
        end
        n_checks++;
        if (fires != 7 || beats != 7) begin
            n_fail++; $display("FAIL single_rate: words=%0d beats=%0d want 7/7", fires, beats);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] words [5];
        logic [7:0]  q [$];
        logic [7:0]  e, pd;
        logic [3:0]  pb;
        logic        pv, pr, pl, piv, fire;
        int          widx = 0;
        int          beats = 0;
        for (int i = 0; i < 5; i++) begin
            words[i] = 32'h04030201 + 32'h10101010 * i;
            for (int k = 0; k < 4; k++) q.push_back(words[i][8*k +: 8]);
        end
        pv = 1'b0; pr = 1'b0; pl = 1'b0; piv = 1'b0; pd = 8'h0; pb = 4'h0;
        tick();
        a_in_dir = 1'b1; a_in_valid = 1'b1; a_in_data = words[0]; a_out_ready = 1'b1;
        for (int cyc = 0; cyc < 300 && beats < 20; cyc++) begin
            @(negedge clk);
            if (pv && !pr) begin
                n_checks++;
                if ({a_out_valid, a_out_data, a_out_bits, a_out_last} !== {1'b1, pd, pb, pl}) begin
                    n_fail++; $display("FAIL b2b_stall: got %b/%h/%0d/%b want 1/%h/%0d/%b",
                                       a_out_valid, a_out_data, a_out_bits, a_out_last, pd, pb, pl);
                end
            end
            if (pv && pr && pl && piv) begin
                n_checks++;
                if (a_out_valid !== 1'b1) begin
                    n_fail++; $display("FAIL b2b_bubble: out_valid got %b want 1", a_out_valid);
                end
            end
            if (a_out_valid && a_out_ready) begin
                n_checks++;
                if (q.size() == 0) begin
                    n_fail++; $display("FAIL b2b_extra: got beat %h want none", a_out_data);
                end else begin
                    e = q.pop_front();
                    if ({a_out_data, a_out_bits, a_out_last} !== {e, 4'd8, (beats % 4) == 3}) begin
                        n_fail++; $display("FAIL b2b_beat%0d: got %h/%0d/%b want %h/8/%b",
                                           beats, a_out_data, a_out_bits, a_out_last, e, (beats % 4) == 3);
                    end
                end
                beats++;
            end
            fire = a_in_valid && a_in_ready;
            pv = a_out_valid; pr = a_out_ready; pl = a_out_last; pd = a_out_data; pb = a_out_bits;
            piv = a_in_valid;
            tick();
            if (fire) widx++;
            a_in_valid  = (widx < 5);
            a_in_data   = (widx < 5) ? words[widx] : 32'h0;
            a_out_ready = ((cyc % 16) < 8) ? 1'b1 : 1'($urandom_range(0, 1));
        end
        n_checks++;
        if (beats != 20 || widx != 5 || q.size() != 0) begin
            n_fail++; $display("FAIL b2b_count: beats=%0d words=%0d left=%0d want 20/5/0", beats, widx, q.size());
        end
        a_in_valid = 1'b0; a_out_ready = 1'b1;
        tick(); tick();
    endtask

    task automatic test_reset_midword();
        logic [31:0] exp = 32'hDDCCBBAA;
        tick();
        a_in_valid = 1'b1; a_in_data = 32'h04030201; a_in_dir = 1'b1; a_out_ready = 1'b1;
        tick();
        a_in_valid = 1'b0;
        tick(); tick();
        @(negedge clk);
        n_checks++;
        if ({a_out_valid, a_out_data} !== {1'b1, 8'h03}) begin
            n_fail++; $display("FAIL rstmid_pre: got v=%b d=%h want v=1 d=03", a_out_valid, a_out_data);
        end
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({a_out_valid, a_in_ready, a_out_data, a_out_last, a_out_bits} !== {1'b0, 1'b1, 8'h00, 1'b0, 4'h0}) begin
            n_fail++; $display("FAIL rstmid_async: got v=%b r=%b d=%h l=%b b=%0d want v=0 r=1 d=00 l=0 b=0",
                               a_out_valid, a_in_ready, a_out_data, a_out_last, a_out_bits);
        end
        tick();
        rst_n = 1'b1;
        a_in_valid = 1'b1; a_in_data = 32'hAABBCCDD; a_in_dir = 1'b1;
        tick();
        a_in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_checks++;
            if ({a_out_valid, a_out_data, a_out_last} !== {1'b1, exp[31-8*k -: 8], k == 3}) begin
                n_fail++; $display("FAIL rstmid_beat%0d: got v=%b d=%h l=%b want v=1 d=%h l=%b",
                                   k, a_out_valid, a_out_data, a_out_last, exp[31-8*k -: 8], k == 3);
            end
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_word32(1'b1, 32'h04030201, 32'h01020304, "ls32");
        test_word32(1'b0, 32'h04030201, 32'h04030201, "rs32");
        test_partial(1'b1, 3'b001, 3'b000, 4'b0010, "ls4x3");
        test_partial(1'b0, 3'b000, 3'b100, 4'b0001, "rs4x3");
        test_single();
        test_back_to_back();
        test_reset_midword();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
